// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES256 row-serial stream stages
// (SubBytes, ShiftRows, MixColumns).
package aes_stream_pkg;

  typedef logic [7:0] byte_t;

  localparam logic SR_ENC = 1'b0;
  localparam logic SR_INV = 1'b1;

  localparam int unsigned NB_DEFAULT = 4;
  localparam int unsigned NR_DEFAULT = 4;

  // Byte rotation applied to a given row index.
  function automatic int unsigned rot_amount(int unsigned row, int unsigned step,
                                             int unsigned nb);
    return (row * step) % nb;
  endfunction

endpackage

// File: rtl/mod_row_rotator.sv
// Combinational byte rotator: left (encrypt) or right (decrypt) by shift_i bytes.
// Also used by the key-schedule RotWord.
module mod_row_rotator #(
  parameter int unsigned NB = 4,
  localparam int unsigned SW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [NB-1:0][7:0] data_i,
  input  logic [SW-1:0]      shift_i,
  input  logic               inv_i,
  output logic [NB-1:0][7:0] data_o
);

  int unsigned       sh;
  logic [SW-1:0]     src;

  always_comb begin
    data_o = '0;
    src    = '0;
    sh     = 32'(shift_i);
    for (int unsigned i = 0; i < NB; i++) begin
      src       = inv_i ? SW'((i + NB - sh) % NB) : SW'((i + sh) % NB);
      data_o[i] = data_i[src];
    end
  end

endmodule

// File: rtl/mod_shiftrows_stream.sv
// Row-serial ShiftRows / InvShiftRows with a one-entry registered output stage,
// valid/ready handshake, last-row flag, done pulse and synchronous flush.
module mod_shiftrows_stream
  import aes_stream_pkg::*;
#(
  parameter int unsigned NB         = NB_DEFAULT,
  parameter int unsigned NR         = NR_DEFAULT,
  parameter int unsigned SHIFT_STEP = 1,
  localparam int unsigned RW        = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NB-1:0][7:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NB-1:0][7:0] out_data,
  output logic [RW-1:0]      out_row,
  output logic               out_inv,
  output logic               out_last,
  output logic               done
);

  localparam int unsigned SW = (NB > 1) ? $clog2(NB) : 1;

  logic [RW-1:0]      row_q, row_d;
  logic               inv_q, inv_d;
  logic               out_valid_q, out_valid_d;
  logic [NB-1:0][7:0] out_data_q, out_data_d;
  logic [RW-1:0]      out_row_q, out_row_d;
  logic               out_inv_q, out_inv_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;

  logic               accept, handoff, cur_inv, row_is_last;
  logic [NB-1:0][7:0] rot_data;
  logic [SW-1:0]      k_tab [NR];

  for (genvar r = 0; r < NR; r++) begin : g_ktab
    assign k_tab[r] = SW'(rot_amount(r, SHIFT_STEP, NB));
  end

  // Row 0 uses the live mode bit; later rows use the one latched on row 0.
  assign cur_inv     = (row_q == '0) ? in_inv : inv_q;
  assign row_is_last = (row_q == RW'(NR - 1));

  mod_row_rotator #(
    .NB (NB)
  ) u_rot (
    .data_i  (in_data),
    .shift_i (k_tab[row_q]),
    .inv_i   (cur_inv),
    .data_o  (rot_data)
  );

  assign in_ready = resetn & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign handoff  = out_valid_q & out_ready;

  always_comb begin
    row_d       = row_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_inv_d   = out_inv_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    if (flush) begin
      row_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      done_d = handoff & out_last_q;
      if (handoff) out_valid_d = 1'b0;
      if (accept) begin
        row_d       = row_is_last ? '0 : row_q + RW'(1);
        out_valid_d = 1'b1;
        out_data_d  = rot_data;
        out_row_d   = row_q;
        out_inv_d   = cur_inv;
        out_last_d  = row_is_last;
        if (row_q == '0) inv_d = in_inv;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_q       <= '0;
      inv_q       <= SR_ENC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_inv_q   <= SR_ENC;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      row_q       <= row_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_inv_q   <= out_inv_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_inv   = out_inv_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: doc/mod_shiftrows_stream.md
Name: mod_shiftrows_stream

Overview:
Row-serial ShiftRows / InvShiftRows engine for the AES256 datapath. It generalises the fixed 4x4 encrypt-only row rotator in three ways: parametrised byte count and row count, a runtime encrypt/decrypt mode, and a valid/ready handshake with backpressure.
It accepts one state row per beat and rotates it by its row index times a step. It emits the result through a single registered output stage, flags the last row of each block, and supports a synchronous flush. It sits between the SubBytes and MixColumns stages in both the encryption and decryption pipelines.

Parameters:
NB, 4, bytes per row (state columns); legal range 2..8
NR, 4, rows per block; legal range 2..8
SHIFT_STEP, 1, rotation bytes per row index; effective shift is (row*SHIFT_STEP) mod NB
RW, max(1,$clog2(NR)), row index width (localparam, derived)

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
flush  input  1  synchronous abort: clears row counter and output stage
in_valid  input  1  in_data holds a valid row
in_ready  output  1  block can accept a row this cycle
in_data  input  [NB-1:0][7:0]  row bytes; byte i at index i
in_inv  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows; sampled only on row 0
out_valid  output  1  out_data holds a valid rotated row
out_ready  input  1  downstream accepts out_data
out_data  output  [NB-1:0][7:0]  rotated row
out_row  output  RW  row index of out_data
out_inv  output  1  mode that out_data was processed with
out_last  output  1  out_data is row NR-1 of its block
done  output  1  one-cycle pulse when the last row of a block is handed off (out_valid & out_ready & out_last)

Behaviour:
- Reset (resetn=0, asynchronous): row counter=0, mode register=0, out_valid=0, out_data=0, out_row=0, out_inv=0, out_last=0, done=0. in_ready is 0 while in reset.
- Handshakes:
  - in_ready = !out_valid | out_ready (combinational; one-entry pipeline).
  - Input accept = in_valid & in_ready. Output handoff = out_valid & out_ready.
- Accept: on an accept edge, out_data/out_row/out_inv/out_last load from the current row. out_valid=1 the next cycle, so latency is 1 cycle.
- Hold: out_valid with !out_ready holds every output field stable. in_ready=0 in this case and no row is consumed.
- Simultaneous handoff and accept in one cycle: the output stage reloads with the new row and out_valid stays 1. Full throughput is one row per cycle.
- Handoff with no accept: out_valid clears next cycle.
- Rotation, with r = current row index and k = (r*SHIFT_STEP) mod NB, computed as a compile-time constant table per row:
  - encrypt: out[i] = in[(i+k) mod NB]
  - decrypt: out[i] = in[(i-k+NB) mod NB]
  - row 0, or k=0, passes through unchanged.
- Mode:
  - On accept of row 0 the mode register latches in_inv; row 0 itself uses in_inv directly.
  - Rows 1..NR-1 use the latched mode and ignore in_inv.
- Row counter:
  - Advances only on accept: NR-1 wraps to 0, otherwise +1.
  - Never advances on an idle or stalled cycle.
- done: registered. Asserted the cycle after a handoff with out_last=1, for exactly one cycle.
- flush (synchronous, highest priority after reset):
  - Next edge: row counter=0, out_valid=0, done=0. out_data is not cleared.
  - Any row presented with flush=1 is dropped, even if in_ready=1.
- Reset mid-block: all state is lost. The next accepted row is treated as row 0.
- Data bits never affect control; there is no X propagation from in_data to out_valid.

Decomposition:
- Package aes_stream_pkg:
  - byte_t typedef (logic [7:0])
  - function rot_amount(row, step, nb)
  - SR_ENC=1'b0 / SR_INV=1'b1 mode constants
  - default NB/NR constants shared with the MixColumns and SubBytes stream blocks
- One sub-module, mod_row_rotator: purely combinational. Parametrised NB; inputs row bytes, shift amount and direction; output rotated bytes. It is reused later by the key-schedule RotWord.
- The top level holds the counter, mode register, output stage and handshake.

Test Plan:
- Encrypt block, NB=NR=4, no stalls: rows 00010203, 10111213, 20212223, 30313233 with in_inv=0 -> 00010203, 11121310, 22232021, 33303132; out_row 0..3; out_last on row 3; done pulses once, one cycle after the row-3 handoff.
- Decrypt block: same rows, in_inv=1 on row 0, in_inv toggled 0/1 on rows 1..3 -> 00010203, 13101112, 22232021, 31323330; out_inv=1 on all four.
- Backpressure: out_ready=0 for 3 cycles while row 1 is held -> out_data stays 11121310, in_ready=0, counter stays at 2; after release, throughput returns to 1 row/cycle.
- Back-to-back blocks (8 rows, continuous valid/ready) -> counter wraps 3->0, block 2 row 0 passes through, done pulses twice.
- Flush after 2 accepted rows, then a new block -> out_valid drops; the next row is treated as row 0 (AABBCCDD unchanged) and no done pulse comes from the aborted block.
- Parameter sweep NB=8, NR=4, SHIFT_STEP=2, encrypt; row 3 input bytes 0..7 -> k=6, out = 06 07 00 01 02 03 04 05. Repeat with resetn asserted mid-block -> all outputs are 0 immediately (asynchronous).
